// File: rtl/timer_mem_interface_pkg.sv
// rtl/timer_mem_interface_pkg.sv - timer region id, register offsets and select encoding
package timer_mem_interface_pkg;

   localparam logic [7:0] TIMER_REGION    = 8'h03;
   localparam logic [7:0] TMR_MTIME_LO    = 8'h00;
   localparam logic [7:0] TMR_MTIME_HI    = 8'h04;
   localparam logic [7:0] TMR_MTIMECMP_LO = 8'h08;
   localparam logic [7:0] TMR_MTIMECMP_HI = 8'h0C;
   localparam logic [7:0] TMR_CTRL        = 8'h10;
   localparam logic [2:0] SIZE_WORD       = 3'b010;

   // Word index inside the region (byte offset >> 2)
   typedef enum logic [2:0] {
      REG_MTIME_LO    = 3'd0,
      REG_MTIME_HI    = 3'd1,
      REG_MTIMECMP_LO = 3'd2,
      REG_MTIMECMP_HI = 3'd3,
      REG_CTRL        = 3'd4
   } reg_sel_e;

endpackage

// File: rtl/timer_mem_interface_prescaler.sv
// rtl/timer_mem_interface_prescaler.sv - prescale counter producing one MTIME tick per PRESC+1 cycles
module timer_prescaler #(
   parameter int PRESC_W = 8
) (
   input  logic               CLK,
   input  logic               reset,
   input  logic               i_en,
   input  logic [PRESC_W-1:0] i_presc,
   input  logic               i_clear,
   output logic               o_tick
);

   logic [PRESC_W-1:0] r_count;

   // A clearing store (MTIME or CTRL) suppresses the tick of that cycle
   assign o_tick = i_en && !i_clear && (r_count == i_presc);

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_count <= '0;
      end else if (i_clear) begin
         r_count <= '0;
      end else if (i_en) begin
         r_count <= o_tick ? '0 : r_count + 1'b1;
      end
   end

endmodule

// File: rtl/timer_mem_interface.sv
// rtl/timer_mem_interface.sv - memory-mapped 64-bit machine timer with compare interrupt
module timer_mem_interface
   import timer_mem_interface_pkg::*;
#(
   parameter int PRESC_W = 8,
   parameter int ADDR_W  = 5
) (
   input  logic              CLK,
   input  logic              reset,
   input  logic              en,
   input  logic              wr,
   input  logic [ADDR_W-1:0] addr,
   input  logic [2:0]        size,
   input  logic [31:0]       data_in,
   output logic [31:0]       data_out,
   output logic              exception_out,
   output logic              timer_irq
);

   logic [63:0]        r_mtime;
   logic [63:0]        r_mtimecmp;
   logic               r_ctrl_en;
   logic [PRESC_W-1:0] r_presc;
   logic [31:0]        r_hi_shadow;
   logic [31:0]        r_data_out;
   logic               r_exc;
   logic               r_irq;

   logic [ADDR_W-3:0]  w_word;
   reg_sel_e           w_sel;
   logic               w_legal;
   logic               w_store;
   logic               w_load;
   logic               w_clear;
   logic               w_tick;
   logic [63:0]        w_mtime_nxt;
   logic [63:0]        w_cmp_nxt;
   logic [31:0]        w_rdata;

   assign w_word  = addr[ADDR_W-1:2];
   assign w_sel   = reg_sel_e'(w_word[2:0]);
   assign w_legal = (size == SIZE_WORD) && (addr[1:0] == 2'b00) &&
                    (32'(w_word) <= 32'(REG_CTRL));
   assign w_store = en && w_legal && wr;
   assign w_load  = en && w_legal && !wr;
   assign w_clear = w_store && (w_sel == REG_MTIME_LO || w_sel == REG_MTIME_HI ||
                                w_sel == REG_CTRL);

   timer_prescaler #(.PRESC_W(PRESC_W)) u_presc (
      .CLK     (CLK),
      .reset   (reset),
      .i_en    (r_ctrl_en),
      .i_presc (r_presc),
      .i_clear (w_clear),
      .o_tick  (w_tick)
   );

   always_comb begin
      w_mtime_nxt = w_tick ? r_mtime + 64'd1 : r_mtime;
      w_cmp_nxt   = r_mtimecmp;
      if (w_store) begin
         case (w_sel)
            REG_MTIME_LO:    w_mtime_nxt[31:0]  = data_in;
            REG_MTIME_HI:    w_mtime_nxt[63:32] = data_in;
            REG_MTIMECMP_LO: w_cmp_nxt[31:0]    = data_in;
            REG_MTIMECMP_HI: w_cmp_nxt[63:32]   = data_in;
            default:         ;
         endcase
      end
   end

   // MTIME_HI reads the shadow captured by the last MTIME_LO load, keeping 64-bit reads coherent
   always_comb begin
      w_rdata = '0;
      case (w_sel)
         REG_MTIME_LO:    w_rdata = r_mtime[31:0];
         REG_MTIME_HI:    w_rdata = r_hi_shadow;
         REG_MTIMECMP_LO: w_rdata = r_mtimecmp[31:0];
         REG_MTIMECMP_HI: w_rdata = r_mtimecmp[63:32];
         REG_CTRL:        w_rdata = 32'({r_presc, 7'h00, r_ctrl_en});
         default:         w_rdata = '0;
      endcase
   end

   always_ff @(posedge CLK or negedge reset) begin
      if (!reset) begin
         r_mtime     <= '0;
         r_mtimecmp  <= '1;
         r_ctrl_en   <= 1'b0;
         r_presc     <= '0;
         r_hi_shadow <= '0;
         r_data_out  <= '0;
         r_exc       <= 1'b0;
         r_irq       <= 1'b0;
      end else begin
         r_mtime    <= w_mtime_nxt;
         r_mtimecmp <= w_cmp_nxt;
         r_exc      <= en && !w_legal;
         r_irq      <= (w_mtime_nxt >= w_cmp_nxt);
         if (w_store && w_sel == REG_CTRL) begin
            r_ctrl_en <= data_in[0];
            r_presc   <= data_in[8 +: PRESC_W];
         end
         if (w_load) begin
            r_data_out <= w_rdata;
            if (w_sel == REG_MTIME_LO) begin
               r_hi_shadow <= r_mtime[63:32];
            end
         end
      end
   end

   assign data_out      = r_data_out;
   assign exception_out = r_exc;
   assign timer_irq     = r_irq;

endmodule
